// File: rtl/keypad_scan_fsm_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad column-scan FSM.
package keypad_scan_fsm_pkg;

    localparam int CODE_W = 4;
    localparam logic [3:0] COL_ALL = 4'b1111;

    // 3-bit state encoding; SCAN0..SCAN3 are kept contiguous so the next scan
    // column is simply the next enumeration value.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        SCAN0    = 3'd2,
        SCAN1    = 3'd3,
        SCAN2    = 3'd4,
        SCAN3    = 3'd5,
        VALID    = 3'd6,
        HOLD     = 3'd7
    } state_t;

    // Index of the lowest set bit; only meaningful when v != 0.
    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Column drive pattern for a state: one-hot while scanning, all columns otherwise.
    function automatic logic [3:0] col_for_state(input state_t s);
        logic [3:0] col;
        case (s)
            SCAN0:   col = 4'b0001;
            SCAN1:   col = 4'b0010;
            SCAN2:   col = 4'b0100;
            SCAN3:   col = 4'b1000;
            default: col = COL_ALL;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/keypad_scan_fsm_if.sv
// Keypad-side and consumer-side signals of the scanner.
// Valid/Code: Valid is a one-cycle strobe; Code is meaningful while Valid is high
// and is held afterwards. There is no ready: the consumer must take the strobe.
interface keypad_scan_fsm_if;
    import keypad_scan_fsm_pkg::*;

    logic [3:0]        Row;
    logic [3:0]        Col;
    logic [CODE_W-1:0] Code;
    logic              Valid;
    state_t            dbg_state;

    modport master (input Row, output Col, output Code, output Valid, output dbg_state);
    modport slave  (output Row, input Col, input Code, input Valid, input dbg_state);
endinterface

// File: rtl/keypad_scan_fsm_sync.sv
// Two-flop synchronizer for the asynchronous row-sense lines.
module keypad_scan_fsm_sync_2ff #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // Two back-to-back flops, both cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan_fsm.sv
// Column-drive / row-sense keypad scanner: debounce, locate key, strobe code, wait release.
module keypad_scan_fsm
    import keypad_scan_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 3
) (
    input logic              clock,
    input logic              reset,
    keypad_scan_fsm_if.master kp
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [3:0]        row_sync;
    logic [1:0]        scan_idx;

    keypad_scan_fsm_sync_2ff #(.W(4)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (kp.Row),
        .q     (row_sync)
    );

    assign kp.dbg_state = state;

    // Next-state, counter and code selection from the synchronized rows.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = kp.Code;
        scan_idx  = 2'd0;
        case (state)
            SCAN1:   scan_idx = 2'd1;
            SCAN2:   scan_idx = 2'd2;
            SCAN3:   scan_idx = 2'd3;
            default: scan_idx = 2'd0;
        endcase
        case (state)
            IDLE: begin
                if (|row_sync) begin
                    state_nxt = DEBOUNCE;
                    cnt_nxt   = '0;
                end
            end
            DEBOUNCE: begin
                if (row_sync == 4'b0000) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = SCAN0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SCAN0, SCAN1, SCAN2, SCAN3: begin
                if (cnt == SET_LAST) begin
                    cnt_nxt = '0;
                    if (|row_sync) begin
                        // Code = 4*row + col; row is the upper two bits.
                        code_nxt  = {lowest_bit(row_sync), scan_idx};
                        state_nxt = VALID;
                    end else if (state == SCAN3) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = state_t'(state + 3'd1);
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            VALID: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
            HOLD: begin
                if (|row_sync) begin
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            kp.Col   <= COL_ALL;
            kp.Code  <= '0;
            kp.Valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            kp.Col   <= col_for_state(state_nxt);
            kp.Code  <= code_nxt;
            kp.Valid <= (state_nxt == VALID);
        end
    end
endmodule
